// File: rtl/ber_checker_pkg.sv
// ber_checker_pkg
// Shared constants for the BER checker: FSM state encoding, the length of
// the error-counting window (one PRBS9 period) and the default reference
// buffer geometry.
package ber_checker_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_EVAL   = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    // One PRBS9 period: every candidate delay is scored over this many symbols.
    localparam int WINDOW_LEN = 511;
    localparam int NB_WINDOW  = 9;

    // Default reference buffer geometry (depth = 2**NB_DELAY_DEF).
    localparam int NB_DELAY_DEF = 9;
    localparam int BUF_DEPTH    = 2 ** NB_DELAY_DEF;

endpackage

// File: rtl/ber_checker_ref_delay_line.sv
// ref_delay_line
// 1-bit wide shift register holding the most recent transmitted reference
// bits, with a random-access read port.
//   clk      : clock, rising edge
//   rst_n    : synchronous active-low reset, clears every entry
//   push     : shift push_bit in this cycle
//   push_bit : reference bit to insert at entry 0 (newest)
//   rd_idx   : entry to read (0 = newest)
//   rd_bit   : combinational read of the contents before this cycle's shift
module ref_delay_line #(
    parameter int NB_DELAY = 9
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic                push_bit,
    input  logic [NB_DELAY-1:0] rd_idx,
    output logic                rd_bit
);

    localparam int DEPTH = 2 ** NB_DELAY;

    logic [DEPTH-1:0] line_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            line_q <= '0;
        end else if (push) begin
            line_q <= {line_q[DEPTH-2:0], push_bit};
        end
    end

    // Reading the registered contents means a push in the same cycle as a
    // read is seen only from the next cycle on.
    assign rd_bit = line_q[rd_idx];

endmodule

// File: rtl/ber_checker.sv
// ber_checker
// Bit-error-rate checker. Slices one sample per symbol from an oversampled
// filter output, searches every reference delay for the one with the fewest
// mismatches over a 511-symbol window, then locks and counts bit errors.
//   i_clk       : clock, rising edge
//   i_rst_n     : synchronous active-low reset
//   i_enable    : one valid filter sample this cycle
//   i_data      : signed filter sample, sign bit is the sliced bit
//   i_phase     : which sample of each symbol is used
//   i_ref_bit   : transmitted reference bit
//   i_ref_valid : push i_ref_bit into the reference buffer
//   i_restart   : one-cycle pulse, restarts the delay search
//   o_locked    : high while locked
//   o_delay     : delay under test (search) or chosen delay (locked)
//   o_err_cnt   : saturating error count since lock
//   o_bit_cnt   : saturating compared-bit count since lock
//   o_state     : FSM state for debug
//
// Interface timing: i_enable, i_ref_valid and i_restart are plain strobes
// sampled on every rising edge; there is no backpressure, the checker
// accepts whatever is presented in a strobed cycle.
module ber_checker
    import ber_checker_pkg::*;
#(
    parameter int NB_INPUT  = 18,
    parameter int OS_FACTOR = 4,
    parameter int NB_COUNT  = 64,
    parameter int NB_DELAY  = NB_DELAY_DEF
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_enable,
    input  logic signed [NB_INPUT-1:0]   i_data,
    input  logic [$clog2(OS_FACTOR)-1:0] i_phase,
    input  logic                         i_ref_bit,
    input  logic                         i_ref_valid,
    input  logic                         i_restart,
    output logic                         o_locked,
    output logic [NB_DELAY-1:0]          o_delay,
    output logic [NB_COUNT-1:0]          o_err_cnt,
    output logic [NB_COUNT-1:0]          o_bit_cnt,
    output logic [1:0]                   o_state
);

    localparam int NB_PHASE = $clog2(OS_FACTOR);
    localparam logic [NB_DELAY-1:0]  LAST_DELAY = '1;
    localparam logic [NB_WINDOW-1:0] LAST_SYM   = NB_WINDOW'(WINDOW_LEN - 1);

    logic [1:0]           state_q;
    logic [NB_PHASE-1:0]  phase_q;
    logic [NB_DELAY-1:0]  delay_q;
    logic [NB_DELAY-1:0]  best_delay_q;
    logic [NB_WINDOW-1:0] win_err_q;
    logic [NB_WINDOW-1:0] best_err_q;
    logic [NB_WINDOW-1:0] sym_cnt_q;
    logic [NB_COUNT-1:0]  err_cnt_q;
    logic [NB_COUNT-1:0]  bit_cnt_q;
    logic                 mismatch_q;
    logic                 cmp_valid_q;

    logic                 strobe;
    logic                 rx_bit;
    logic                 ref_bit;
    logic                 new_best;
    logic [NB_DELAY-1:0]  chosen_delay;

    assign strobe       = i_enable && (phase_q == i_phase);
    assign rx_bit       = i_data[NB_INPUT-1];
    // Strict comparison: on a tie the earlier delay stays the best.
    assign new_best     = (win_err_q < best_err_q);
    assign chosen_delay = new_best ? delay_q : best_delay_q;

    ref_delay_line #(
        .NB_DELAY (NB_DELAY)
    ) u_ref_delay_line (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .push     (i_ref_valid),
        .push_bit (i_ref_bit),
        .rd_idx   (delay_q),
        .rd_bit   (ref_bit)
    );

    // Phase counter keeps running across restarts so the chosen sampling
    // phase stays aligned to the sample stream; OS_FACTOR is a power of two,
    // so the natural wrap is the modulo.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            phase_q <= '0;
        end else if (i_enable) begin
            phase_q <= phase_q + 1'b1;
        end
    end

    // Mismatch pipeline. A comparison is only tagged valid when it was made
    // in SEARCH or LOCKED, so a result computed with the previous delay (in
    // EVAL) can never leak into the next window.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_restart) begin
            mismatch_q  <= 1'b0;
            cmp_valid_q <= 1'b0;
        end else begin
            cmp_valid_q <= strobe && ((state_q == ST_SEARCH) || (state_q == ST_LOCKED));
            if (strobe) begin
                mismatch_q <= rx_bit ^ ref_bit;
            end
        end
    end

    // Search / lock FSM
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_restart) begin
            state_q      <= ST_SEARCH;
            delay_q      <= '0;
            best_delay_q <= '0;
            win_err_q    <= '0;
            best_err_q   <= '1;
            sym_cnt_q    <= '0;
            err_cnt_q    <= '0;
            bit_cnt_q    <= '0;
        end else begin
            case (state_q)
                ST_SEARCH: begin
                    if (cmp_valid_q) begin
                        win_err_q <= win_err_q + NB_WINDOW'(mismatch_q);
                        sym_cnt_q <= sym_cnt_q + 1'b1;
                        if (sym_cnt_q == LAST_SYM) begin
                            state_q <= ST_EVAL;
                        end
                    end
                end
                ST_EVAL: begin
                    if (new_best) begin
                        best_err_q   <= win_err_q;
                        best_delay_q <= delay_q;
                    end
                    if (delay_q == LAST_DELAY) begin
                        state_q   <= ST_LOCKED;
                        delay_q   <= chosen_delay;
                        err_cnt_q <= '0;
                        bit_cnt_q <= '0;
                    end else begin
                        state_q   <= ST_SEARCH;
                        delay_q   <= delay_q + 1'b1;
                        win_err_q <= '0;
                        sym_cnt_q <= '0;
                    end
                end
                ST_LOCKED: begin
                    if (cmp_valid_q) begin
                        if (bit_cnt_q != '1) begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                        if (mismatch_q && (err_cnt_q != '1)) begin
                            err_cnt_q <= err_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_SEARCH;
                end
            endcase
        end
    end

    assign o_locked  = (state_q == ST_LOCKED);
    assign o_delay   = delay_q;
    assign o_err_cnt = err_cnt_q;
    assign o_bit_cnt = bit_cnt_q;
    assign o_state   = state_q;

endmodule
